matmul_seq: RTL

Parametrised, sequential N×N unsigned matrix multiplier computing Res = A·B with one multiply-accumulate per clock. It accepts both operand matrices in one valid/ready beat, iterates i/j/k internally, and presents the full result matrix on a valid/ready output. It is the scalable successor to the fixed 2×2, 8-bit, single-cycle matrix multiplier in the benchmark set. Compared with that block it has:

- configurable size and widths;
- non-truncating accumulation;
- flow control;
- optional saturation.

---
 rtl/matmul_seq_if.sv | 28 ++
 rtl/matmul_seq.sv | 131 +++++++++++++
 2 files changed

// File: rtl/matmul_seq_if.sv
// Operand/result handshake bundle for matmul_seq.
// Carries both flattened operand matrices in, and the flattened result plus status out.
// Master drives operands and out_ready; slave (the multiplier) drives everything else.
interface matmul_seq_if #(
    parameter int N     = 2,
    parameter int DW    = 8,
    parameter int OUT_W = 17
);
    logic                   in_valid;
    logic                   in_ready;
    logic [N*N*DW-1:0]      A;
    logic [N*N*DW-1:0]      B;
    logic                   out_valid;
    logic                   out_ready;
    logic [N*N*OUT_W-1:0]   Res;
    logic                   ovf;
    logic                   busy;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, Res, ovf, busy
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, Res, ovf, busy
    );
endinterface

// File: rtl/matmul_seq.sv
// Sequential NxN unsigned matrix multiply, one MAC per clock; MATMUL_SAT_EN clamps narrow results.
// Latency N^3+1 cycles from operand accept to out_valid; one job per N^3+2 cycles.
// in_ready only in IDLE; result held in DONE until out_ready, no overlap with the next job.
module matmul_seq #(
    parameter int N     = 2,
    parameter int DW    = 8,
    parameter int OUT_W = 17
) (
    input  logic        clk,
    input  logic        reset,
    matmul_seq_if.slave io
);
    localparam int ACC_W = 2*DW + $clog2(N);
    localparam int CW    = $clog2(N);

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      i_q, j_q, k_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   sum;
    logic [2*DW-1:0]    prod;
    logic [DW-1:0]      a_m [N][N];
    logic [DW-1:0]      b_m [N][N];
    logic [OUT_W-1:0]   res_m [N][N];
    logic [OUT_W-1:0]   res_val;
    logic               ovf_q;
    logic               elem_ovf;
    logic               last_k, last_j, last_i, last_mac;
    logic               accept;

    assign last_k   = (k_q == CW'(N-1));
    assign last_j   = (j_q == CW'(N-1));
    assign last_i   = (i_q == CW'(N-1));
    assign last_mac = last_k && last_j && last_i;
    assign accept   = io.in_valid && (state_q == IDLE);

    // Accumulator is sized so N full-scale products can never wrap.
    assign prod = {{DW{1'b0}}, a_m[i_q][k_q]} * {{DW{1'b0}}, b_m[k_q][j_q]};
    assign sum  = acc_q + {{(ACC_W-2*DW){1'b0}}, prod};

    generate
        if (OUT_W >= ACC_W) begin : g_wide
            assign res_val  = OUT_W'(sum);
            assign elem_ovf = 1'b0;
        end else begin : g_narrow
            logic hi_nz;
            assign hi_nz = |sum[ACC_W-1:OUT_W];
`ifdef MATMUL_SAT_EN
            assign res_val = hi_nz ? {OUT_W{1'b1}} : sum[OUT_W-1:0];
`else
            assign res_val = sum[OUT_W-1:0];
`endif
            assign elem_ovf = hi_nz;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (io.in_valid)  state_d = COMPUTE;
            COMPUTE: if (last_mac)     state_d = DONE;
            DONE:    if (io.out_ready) state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            acc_q <= '0;
            ovf_q <= 1'b0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_m[r][c]   <= '0;
                    b_m[r][c]   <= '0;
                    res_m[r][c] <= '0;
                end
            end
        end else if (accept) begin
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            acc_q <= '0;
            ovf_q <= 1'b0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_m[r][c] <= io.A[(N*N-1-(r*N+c))*DW +: DW];
                    b_m[r][c] <= io.B[(N*N-1-(r*N+c))*DW +: DW];
                end
            end
        end else if (state_q == COMPUTE) begin
            if (last_k) begin
                res_m[i_q][j_q] <= res_val;
                ovf_q           <= ovf_q | elem_ovf;
                acc_q           <= '0;
                k_q             <= '0;
                if (last_j) begin
                    j_q <= '0;
                    i_q <= last_i ? '0 : i_q + 1'b1;
                end else begin
                    j_q <= j_q + 1'b1;
                end
            end else begin
                acc_q <= sum;
                k_q   <= k_q + 1'b1;
            end
        end
    end

    always_comb begin
        io.Res = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                io.Res[(N*N-1-(r*N+c))*OUT_W +: OUT_W] = res_m[r][c];
            end
        end
    end

    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = (state_q == DONE);
    assign io.busy      = (state_q != IDLE);
    assign io.ovf       = ovf_q;
endmodule
